// File: rtl/seven_segment_reader.sv
// Seven-segment pin observer: synchronizes and debounces the segment pins,
// then decodes the lit pattern back to a hex digit and counts invalid patterns.
module seven_segment_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Segment_A,
    input  logic       i_Segment_B,
    input  logic       i_Segment_C,
    input  logic       i_Segment_D,
    input  logic       i_Segment_E,
    input  logic       i_Segment_F,
    input  logic       i_Segment_G,
    output logic [3:0] o_Binary_Num,
    output logic       o_Valid,
    output logic       o_New_Digit,
    output logic       o_Invalid_Pulse,
    output logic [7:0] o_Error_Count
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic UNLIT = (ACTIVE_LOW != 0);

    logic [6:0] pins;
    logic [6:0] sync1;
    logic [6:0] sync2;
    logic [6:0] pattern;
    logic [6:0] candidate;
    logic [CW-1:0] count;
    logic accepted;
    logic [3:0] digit;
    logic is_hex;
    logic is_blank;
    logic same;
    logic fire;

    assign pins = {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                   i_Segment_E, i_Segment_F, i_Segment_G};

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync1 <= {7{UNLIT}};
            sync2 <= {7{UNLIT}};
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
        end
    end

    // Normalised so that 1 always means the segment is lit.
    assign pattern = UNLIT ? ~sync2 : sync2;

    always_comb begin
        digit  = 4'h0;
        is_hex = 1'b1;
        case (pattern)
            7'h7E: digit = 4'h0;
            7'h30: digit = 4'h1;
            7'h6D: digit = 4'h2;
            7'h79: digit = 4'h3;
            7'h33: digit = 4'h4;
            7'h5B: digit = 4'h5;
            7'h5F: digit = 4'h6;
            7'h70: digit = 4'h7;
            7'h7F: digit = 4'h8;
            7'h7B: digit = 4'h9;
            7'h77: digit = 4'hA;
            7'h1F: digit = 4'hB;
            7'h4E: digit = 4'hC;
            7'h3D: digit = 4'hD;
            7'h4F: digit = 4'hE;
            7'h47: digit = 4'hF;
            default: is_hex = 1'b0;
        endcase
    end

    assign is_blank = (pattern == 7'h00);
    assign same     = (pattern == candidate);
    assign fire     = same && (count == CNT_MAX) && !accepted;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            candidate <= 7'h00;
            count     <= CNT_MAX;
            accepted  <= 1'b1;
        end else if (!same) begin
            candidate <= pattern;
            count     <= '0;
            accepted  <= 1'b0;
        end else if (count != CNT_MAX) begin
            count <= count + 1'b1;
        end else if (!accepted) begin
            accepted <= 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Binary_Num    <= 4'h0;
            o_Valid         <= 1'b0;
            o_New_Digit     <= 1'b0;
            o_Invalid_Pulse <= 1'b0;
            o_Error_Count   <= 8'h00;
        end else begin
            o_New_Digit     <= 1'b0;
            o_Invalid_Pulse <= 1'b0;
            if (fire) begin
                if (is_hex) begin
                    // A glitch that settles back on the shown digit is silent.
                    if (!o_Valid || digit != o_Binary_Num) begin
                        o_Binary_Num <= digit;
                        o_Valid      <= 1'b1;
                        o_New_Digit  <= 1'b1;
                    end
                end else if (is_blank) begin
                    o_Valid <= 1'b0;
                end else begin
                    o_Valid         <= 1'b0;
                    o_Invalid_Pulse <= 1'b1;
                    if (o_Error_Count != 8'hFF)
                        o_Error_Count <= o_Error_Count + 8'h01;
                end
            end
        end
    end

endmodule

// File: doc/seven_segment_reader.md
Name: seven_segment_reader

Overview:
- Observing end of the seven-segment interface. Samples the seven segment pins, filters glitches, and decodes the lit pattern back to a 4-bit hex digit.
- Flags invalid patterns and counts them.
- Used as an on-board loopback checker behind the counter/display path, and as a decoder for external 7-segment sources at the 25 MHz board clock.

Parameters:
- STABLE_CYCLES, 4, consecutive cycles a pattern must hold before acceptance; legal range >=2; board builds use 250000 (10 ms).
- ACTIVE_LOW, 1, 1 = pin low means segment lit (board polarity); 0 = pin high means lit.

Ports:
- i_Clk  in  1  main 25 MHz clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Segment_A .. i_Segment_G  in  1 each  segment pins, seven separate ports.
- o_Binary_Num  out  4  last accepted valid digit.
- o_Valid  out  1  level; 1 while the accepted pattern is a valid hex digit.
- o_New_Digit  out  1  one-cycle pulse when o_Binary_Num/o_Valid take a new valid digit.
- o_Invalid_Pulse  out  1  one-cycle pulse when a non-blank, non-hex pattern is accepted.
- o_Error_Count  out  8  count of invalid acceptances; saturates at 255.

Behaviour:
- Reset is synchronous and active-high on i_Clk. All state is clocked on i_Clk; no other clock.
- Input stage: two-flop synchronizer per segment. Reset value is the unlit pin level (1 when ACTIVE_LOW=1). After the second flop, polarity is normalised to lit=1, giving a 7-bit pattern {A,B,C,D,E,F,G}.
- Stability filter:
  - Candidate register, stability counter of width $clog2(STABLE_CYCLES), and an accepted flag.
  - Pattern != candidate: candidate <= pattern, counter <= 0, accepted <= 0.
  - Pattern == candidate, counter < STABLE_CYCLES-1: counter increments.
  - Counter == STABLE_CYCLES-1 and accepted=0: acceptance fires and accepted <= 1. The counter holds, so there is exactly one acceptance per stable run.
- Latency: outputs and pulses update on the (STABLE_CYCLES+3)th rising edge, counting the edge that first samples the new pin value as edge 1. With STABLE_CYCLES=4 this is edge 7.
- Decode table (lit segments -> value):
  - 0 = ABCDEF, 1 = BC, 2 = ABDEG, 3 = ABCDG
  - 4 = BCFG, 5 = ACDFG, 6 = ACDEFG, 7 = ABC
  - 8 = ABCDEFG, 9 = ABCDFG, A = ABCEFG, b = CDEFG
  - C = ADEF, d = BCDEG, E = ADEFG, F = AEFG
- On acceptance:
  - Valid digit, and o_Valid=0 or digit != o_Binary_Num: o_Binary_Num <= digit, o_Valid <= 1, o_New_Digit pulses.
  - Valid digit equal to the current o_Binary_Num with o_Valid=1: no change, no pulse. This covers a glitch that returns to the same digit.
  - Blank (all unlit): o_Valid <= 0, o_Binary_Num holds, no pulse, no error.
  - Any other pattern: o_Valid <= 0, o_Binary_Num holds, o_Invalid_Pulse pulses, o_Error_Count increments unless already 255.
- Any change in the pattern before acceptance restarts filtering. A glitch shorter than STABLE_CYCLES cycles is never accepted.
- Pulses are high for exactly one cycle and are never both high in the same cycle.
- Reset values:
  - o_Binary_Num=0, o_Valid=0, o_New_Digit=0, o_Invalid_Pulse=0, o_Error_Count=0.
  - Candidate=blank, counter=STABLE_CYCLES-1, accepted=1, so a blank display after reset produces no events.
- Reset asserted mid-filter or mid-pulse: all state returns to reset values on that edge. The pulse drops and any pending acceptance is discarded.

Test Plan (STABLE_CYCLES=4, ACTIVE_LOW=1):
- Reset, pins all 1 for 20 cycles -> all outputs 0, no pulses.
- Drive the pins for "5" (ACDFG lit, i.e. B,E low=0 false; A,C,D,F,G=0, B,E=1) and hold -> on edge 7, o_Binary_Num=5, o_Valid=1, one-cycle o_New_Digit; nothing further while held.
- From "5", pulse pins to "6" for 3 cycles then back to "5" -> no pulse, o_Binary_Num stays 5.
- Step through all 16 encodings, each held 10 cycles -> o_Binary_Num = 0..F in order, 16 New_Digit pulses, error count 0.
- Drive A+G only lit and hold -> o_Valid=0, one o_Invalid_Pulse, o_Error_Count=1, o_Binary_Num holds. Then 300 alternations invalid/blank -> count saturates at 255.
- Drive "3", then blank, then "3" again, each held 10 cycles -> New_Digit on the first "3", o_Valid=0 during blank, New_Digit again on the second "3". Assert i_Reset at filter cycle 2 of a new digit -> no acceptance, all outputs 0.
